// File: rtl/grn_attractor_ctrl.sv
// grn_attractor_ctrl: Floyd cycle-detection sequencer driving a dual-state gene-network node bank
module grn_attractor_ctrl #(
    parameter int NODES = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NODES-1:0] init_vec,
    input  logic [CNT_W-1:0] max_steps,
    input  logic [NODES-1:0] s0_vec,
    input  logic [NODES-1:0] s1_vec,
    output logic             reset_nos,
    output logic [NODES-1:0] init_state,
    output logic             start_s0,
    output logic             start_s1,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             timeout,
    output logic [CNT_W-1:0] mu,
    output logic [CNT_W-1:0] lambda
);
    typedef enum logic [3:0] {
        IDLE, LOAD1, M_STEP, M_CHK, L_STEP, L_CHK, LOAD2, LEAD, MU_CHK, MU_STEP, MU_ARM, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d, c_q, c_d, mu_q, mu_d, lambda_q, lambda_d, max_q, max_d;
    logic [NODES-1:0] init_q, init_d;
    logic             busy_q, busy_d, found_q, found_d, timeout_q, timeout_d;
    logic             eq;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign eq         = s0_vec == s1_vec;
    assign init_state = init_q;
    assign busy       = busy_q;
    assign done       = state_q == DONE;
    assign found      = found_q;
    assign timeout    = timeout_q;
    assign mu         = mu_q;
    assign lambda     = lambda_q;
    assign reset_nos  = state_q inside {LOAD1, LOAD2};
    assign start_s1   = state_q inside {M_STEP, L_STEP, LEAD, MU_STEP};
    // Tortoise moves on even hare steps: advance pulse in M_STEP, arm pulse in M_CHK.
    assign start_s0   = (state_q == M_STEP && !sat_inc(k_q)[0]) || (state_q == M_CHK && !k_q[0])
                        || state_q inside {MU_STEP, MU_ARM};

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        c_d       = c_q;
        mu_d      = mu_q;
        lambda_d  = lambda_q;
        max_d     = max_q;
        init_d    = init_q;
        busy_d    = busy_q;
        found_d   = found_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (start) begin
                init_d    = init_vec;
                max_d     = (max_steps == '0) ? CNT_W'(1) : max_steps;
                busy_d    = 1'b1;
                mu_d      = '0;
                lambda_d  = '0;
                k_d       = '0;
                found_d   = 1'b0;
                timeout_d = 1'b0;
                state_d   = LOAD1;
            end
            LOAD1: state_d = M_STEP;
            M_STEP: begin
                k_d     = sat_inc(k_q);
                state_d = M_CHK;
            end
            M_CHK: begin
                lambda_d  = eq ? '0 : lambda_q;
                timeout_d = !eq && k_q == max_q;
                state_d   = eq ? L_STEP : (k_q == max_q) ? DONE : M_STEP;
            end
            L_STEP: begin
                lambda_d = sat_inc(lambda_q);
                state_d  = L_CHK;
            end
            L_CHK: begin
                timeout_d = !eq && lambda_q == max_q;
                state_d   = eq ? LOAD2 : (lambda_q == max_q) ? DONE : L_STEP;
            end
            LOAD2: begin
                c_d     = '0;
                state_d = LEAD;
            end
            LEAD: begin
                c_d     = sat_inc(c_q);
                state_d = (sat_inc(c_q) == lambda_q) ? MU_CHK : LEAD;
            end
            MU_CHK: begin
                found_d   = eq;
                timeout_d = !eq && mu_q == max_q;
                state_d   = (eq || mu_q == max_q) ? DONE : MU_STEP;
            end
            MU_STEP: begin
                mu_d    = sat_inc(mu_q);
                state_d = MU_ARM;
            end
            MU_ARM: state_d = MU_CHK;
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            c_q       <= '0;
            mu_q      <= '0;
            lambda_q  <= '0;
            max_q     <= '0;
            init_q    <= '0;
            busy_q    <= 1'b0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            c_q       <= c_d;
            mu_q      <= mu_d;
            lambda_q  <= lambda_d;
            max_q     <= max_d;
            init_q    <= init_d;
            busy_q    <= busy_d;
            found_q   <= found_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// tb_grn_attractor_ctrl: LUT-modelled node bank with a scoreboard of reference Floyd results
module tb_grn_attractor_ctrl;
    localparam int N = 2;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] mu;
        logic [W-1:0] lam;
        logic         found;
        logic         tmo;
        logic [W-1:0] rn;
        logic [W-1:0] s1;
    } res_t;

    logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [N-1:0] init_vec = '0;
    logic [W-1:0] max_steps = '0;
    logic [N-1:0] s0_vec = '0, s1_vec = '0;
    logic         reset_nos, start_s0, start_s1, busy, done, found, timeout;
    logic [N-1:0] init_state;
    logic [W-1:0] mu, lambda;
    logic [1:0]   f [4];
    logic         pass_m = 1'b1;
    int           rn_cnt = 0, s1_cnt = 0;
    int           checks = 0, errors = 0;
    res_t         exp_q[$];

    grn_attractor_ctrl #(.NODES(N), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec), .max_steps(max_steps),
        .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .busy(busy), .done(done), .found(found),
        .timeout(timeout), .mu(mu), .lambda(lambda)
    );

    always #5 clk = ~clk;

    // Node bank: every node shares strobes, so one pass bit and two LUT-driven state vectors suffice.
    always @(posedge clk) begin
        if (start && !busy) begin
            rn_cnt <= 0;
            s1_cnt <= 0;
        end else begin
            rn_cnt <= rn_cnt + int'(reset_nos);
            s1_cnt <= s1_cnt + int'(start_s1);
        end
        if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            pass_m <= 1'b1;
        end else begin
            if (start_s1) s1_vec <= f[s1_vec];
            if (start_s0) begin
                if (pass_m) s0_vec <= f[s0_vec];
                pass_m <= !pass_m;
            end
        end
    end

    function automatic res_t ref_model(input logic [1:0] x0, input int mx);
        res_t       r;
        logic [1:0] h, t;
        int         k, lam, m_u, m;
        m = (mx == 0) ? 1 : mx;
        r = '0;
        h = x0;
        t = x0;
        k = 0;
        do begin
            k++;
            h = f[h];
            if (k % 2 == 0) t = f[t];
        end while (h != t && k != m);
        r.s1 = W'(k);
        r.rn = W'(1);
        if (h != t) begin
            r.tmo = 1'b1;
            return r;
        end
        lam = 0;
        do begin
            lam++;
            h = f[h];
        end while (h != t && lam != m);
        r.lam = W'(lam);
        r.s1  = W'(k + lam);
        if (h != t) begin
            r.tmo = 1'b1;
            return r;
        end
        r.rn = W'(2);
        h = x0;
        t = x0;
        for (int i = 0; i < lam; i++) h = f[h];
        m_u = 0;
        while (h != t && m_u != m) begin
            m_u++;
            h = f[h];
            t = f[t];
        end
        r.mu    = W'(m_u);
        r.s1    = W'(k + 2 * lam + m_u);
        r.found = h == t;
        r.tmo   = h != t;
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("mu=%0d lambda=%0d found=%0b timeout=%0b resets=%0d s1_strobes=%0d",
                         r.mu, r.lam, r.found, r.tmo, r.rn, r.s1);
    endfunction

    task automatic set_lut(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
        f[0] = a;
        f[1] = b;
        f[2] = c;
        f[3] = d;
    endtask

    task automatic launch(input logic [1:0] x0, input logic [W-1:0] mx);
        exp_q.push_back(ref_model(x0, int'(mx)));
        @(negedge clk);
        init_vec  = x0;
        max_steps = mx;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic await_done(output bit ok, output res_t obs);
        ok  = 1'b0;
        obs = '0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        obs.mu    = mu;
        obs.lam   = lambda;
        obs.found = found;
        obs.tmo   = timeout;
        obs.rn    = W'(rn_cnt);
        obs.s1    = W'(s1_cnt);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, found, timeout, reset_nos, start_s0, start_s1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 0000000",
                     {busy, done, found, timeout, reset_nos, start_s0, start_s1});
        end
        checks++;
        if ({mu, lambda, init_state} !== '0) begin
            errors++;
            $display("FAIL reset_values: got mu=%0d lambda=%0d init_state=%0d, expected all 0", mu, lambda, init_state);
        end
        rst = 1'b1;
    endtask

    task automatic test_fixed_point;
        bit ok;
        res_t obs, e;
        set_lut(2'd0, 2'd2, 2'd3, 2'd1);
        launch(2'd0, W'(50));
        await_done(ok, obs);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL fixed_point_done: no done within budget"); end
        checks++;
        if (obs !== e) begin errors++; $display("FAIL fixed_point: got %s, expected %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_chain;
        bit ok;
        res_t obs, e;
        set_lut(2'd1, 2'd2, 2'd3, 2'd1);
        launch(2'd0, W'(50));
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL chain_busy: got %b, expected 1", busy); end
        await_done(ok, obs);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL chain_done: no done within budget"); end
        checks++;
        if (obs !== e) begin errors++; $display("FAIL chain: got %s, expected %s", fmt(obs), fmt(e)); end
        checks++;
        if (obs.mu !== W'(1) || obs.lam !== W'(3)) begin
            errors++;
            $display("FAIL chain_mu_lambda: got mu=%0d lambda=%0d, expected mu=1 lambda=3", obs.mu, obs.lam);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL chain_done_width: got done,busy=%b, expected 00", {done, busy}); end
    endtask

    task automatic test_cycle4;
        bit ok;
        res_t obs, e;
        set_lut(2'd1, 2'd2, 2'd3, 2'd0);
        launch(2'd0, W'(50));
        await_done(ok, obs);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL cycle4_done: no done within budget"); end
        checks++;
        if (obs !== e) begin errors++; $display("FAIL cycle4: got %s, expected %s", fmt(obs), fmt(e)); end
        checks++;
        if (obs.rn !== W'(2)) begin errors++; $display("FAIL cycle4_resets: got %0d, expected 2", obs.rn); end
    endtask

    task automatic test_timeout;
        bit ok;
        res_t obs, e;
        set_lut(2'd1, 2'd2, 2'd3, 2'd1);
        launch(2'd0, W'(2));
        await_done(ok, obs);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_done: no done within budget"); end
        checks++;
        if (obs !== e) begin errors++; $display("FAIL timeout_max2: got %s, expected %s", fmt(obs), fmt(e)); end
        launch(2'd0, W'(0));
        await_done(ok, obs);
        e = exp_q.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL timeout_max0: done=%0b got %s, expected %s", ok, fmt(obs), fmt(e));
        end
    endtask

    task automatic test_reset_midrun;
        bit ok, hit;
        int extra;
        res_t obs, e;
        set_lut(2'd1, 2'd2, 2'd3, 2'd1);
        @(negedge clk);
        init_vec  = 2'd0;
        max_steps = W'(50);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start_s1 && s1_cnt == 5) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midrun_reach_lstep: hare lap phase not reached"); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            extra += int'(done);
        end
        checks++;
        if (extra != 0 || busy !== 1'b0 || lambda !== '0) begin
            errors++;
            $display("FAIL midrun_abort: got dones=%0d busy=%b lambda=%0d, expected 0 0 0", extra, busy, lambda);
        end
        launch(2'd0, W'(50));
        await_done(ok, obs);
        e = exp_q.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL midrun_rerun: done=%0b got %s, expected %s", ok, fmt(obs), fmt(e));
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int extra;
        res_t obs, e;
        set_lut(2'd1, 2'd2, 2'd3, 2'd1);
        launch(2'd0, W'(50));
        repeat (4) @(negedge clk);
        init_vec = 2'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        await_done(ok, obs);
        e = exp_q.pop_front();
        checks++;
        if (!ok || obs !== e) begin
            errors++;
            $display("FAIL busy_start: done=%0b got %s, expected %s", ok, fmt(obs), fmt(e));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: got busy=%b, expected 0", busy); end
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            extra += int'(done);
        end
        checks++;
        if (extra != 0 || mu !== e.mu || lambda !== e.lam || init_state !== 2'd0) begin
            errors++;
            $display("FAIL single_done: got dones=%0d mu=%0d lambda=%0d init_state=%0d, expected 0 %0d %0d 0",
                     extra, mu, lambda, init_state, e.mu, e.lam);
        end
    endtask

    initial begin
        set_lut(2'd0, 2'd0, 2'd0, 2'd0);
        test_reset;
        test_fixed_point;
        test_chain;
        test_cycle4;
        test_timeout;
        test_reset_midrun;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
